// File: rtl/ahb_ext_sram.sv
// AHB-Lite subordinate modelling off-chip RAM on the external bus port.
// Supports programmable wait states, byte-strobed writes and two-cycle ERROR responses.
module ahb_ext_sram #(
    parameter int                  AHBW       = 64,
    parameter int                  PA_BITS    = 56,
    parameter logic [PA_BITS-1:0]  BASE       = 56'h0080000000,
    parameter int                  RAM_BYTES  = 65536,
    parameter int                  WAITSTATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  HSELEXT,
    input  logic [PA_BITS-1:0]    HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [AHBW-1:0]       HWDATA,
    input  logic [AHBW/8-1:0]     HWSTRB,
    input  logic                  HREADY,
    output logic [AHBW-1:0]       HRDATAEXT,
    output logic                  HREADYEXT,
    output logic                  HRESPEXT
);
    localparam int                 NBYTES   = AHBW / 8;
    localparam int                 LOG2B    = $clog2(NBYTES);
    localparam int                 RAM_AW   = $clog2(RAM_BYTES);
    localparam int                 IDX_W    = RAM_AW - LOG2B;
    localparam int                 WORDS    = RAM_BYTES / NBYTES;
    localparam logic [PA_BITS-1:0] RAM_SIZE = PA_BITS'(RAM_BYTES);
    localparam logic [2:0]         MAX_SIZE = 3'(LOG2B);
    localparam logic [3:0]         WS_INIT  = 4'((WAITSTATES == 0) ? 0 : WAITSTATES - 1);

    typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

    state_t             state, next;
    logic [3:0]         cnt;
    logic [IDX_W-1:0]   idx;
    logic               wr;
    logic [AHBW-1:0]    mem [WORDS];

    logic [PA_BITS-1:0] off;
    logic [7:0]         size_mask;
    logic               err_in, accept;
    logic               unused;

    assign unused    = HTRANS[0];
    assign off       = HADDR - BASE;
    assign size_mask = (8'd1 << HSIZE) - 8'd1;
    // Addresses below BASE wrap to a huge offset and fall into the range error.
    assign err_in    = (off >= RAM_SIZE) || (HSIZE > MAX_SIZE) || (|(HADDR[7:0] & size_mask));
    assign accept    = HSELEXT & HTRANS[1] & HREADY & HREADYEXT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            wr    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                idx <= off[RAM_AW-1:LOG2B];
                wr  <= HWRITE;
                cnt <= WS_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, LAST, ERR2: begin
                if (!accept)         next = IDLE;
                else if (err_in)     next = ERR1;
                else if (WAITSTATES > 0) next = WAIT;
                else                 next = LAST;
            end
            WAIT:    next = (cnt == 4'd0) ? LAST : WAIT;
            ERR1:    next = ERR2;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        HREADYEXT = 1'b1;
        HRESPEXT  = 1'b0;
        HRDATAEXT = '0;
        case (state)
            WAIT: HREADYEXT = 1'b0;
            ERR1: begin
                HREADYEXT = 1'b0;
                HRESPEXT  = 1'b1;
            end
            ERR2: HRESPEXT = 1'b1;
            // Asynchronous array read: a write closing on the previous edge is already visible.
            LAST: if (!wr) HRDATAEXT = mem[idx];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && state == LAST && wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (HWSTRB[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahb_ext_sram.sv
// Bench for ahb_ext_sram: three instances (2, 0, 3 wait states) on a shared bus,
// directed steps with a queue of expected data-phase results.
module tb_ahb_ext_sram;
    localparam logic [55:0] B = 56'h0080000000;

    typedef struct {
        logic [63:0] rdata;
        logic        resp;
        int          waits;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       sel = '0;
    logic [55:0]      haddr = '0;
    logic [1:0]       htrans = '0;
    logic             hwrite = 1'b0;
    logic [2:0]       hsize = '0;
    logic [63:0]      hwdata = '0;
    logic [7:0]       hwstrb = '0;
    logic [2:0][63:0] rdata;
    logic [2:0]       rdy, resp;

    exp_t sb[$];
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_ext_sram #(
            .WAITSTATES((g == 0) ? 2 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .HSELEXT   (sel[g]),
            .HADDR     (haddr),
            .HTRANS    (htrans),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HWDATA    (hwdata),
            .HWSTRB    (hwstrb),
            .HREADY    (rdy[g]),
            .HRDATAEXT (rdata[g]),
            .HREADYEXT (rdy[g]),
            .HRESPEXT  (resp[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; expectation queued at address phase, checked at completion.
    task automatic xfer(input string tag, input int k, input logic [55:0] a, input logic w,
                        input logic [2:0] sz, input logic [63:0] wd, input logic [7:0] st,
                        input logic [63:0] erd, input logic eresp, input int ewait);
        exp_t e;
        int   waits;
        logic wresp_bad;
        sb.push_back('{erd, eresp, ewait});
        @(negedge clk);
        sel = '0; sel[k] = 1'b1;
        haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
        @(posedge clk); #1;
        sel = '0; htrans = 2'b00; hwdata = wd; hwstrb = st;
        waits = 0; wresp_bad = 1'b0;
        @(negedge clk);
        while (!rdy[k] && waits < 40) begin
            waits++;
            if (resp[k] !== eresp) wresp_bad = 1'b1;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, ".waits"}, 64'(waits), 64'(e.waits));
        check({tag, ".wresp"}, 64'(wresp_bad), 64'd0);
        check({tag, ".resp"}, 64'(resp[k]), 64'(e.resp));
        check({tag, ".rdata"}, rdata[k], e.rdata);
        @(negedge clk);
        check({tag, ".idle"}, {62'd0, rdy[k], resp[k]}, 64'd2);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d.rdy", k), 64'(rdy[k]), 64'd1);
            check($sformatf("rst%0d.resp", k), 64'(resp[k]), 64'd0);
            check($sformatf("rst%0d.rdata", k), rdata[k], 64'd0);
        end

        // Two wait states, full-word write then read
        xfer("t1w", 0, B + 56'h10, 1'b1, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0, 2);
        xfer("t1r", 0, B + 56'h10, 1'b0, 3'd3, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 2);

        // Byte strobes
        xfer("t2p", 0, B + 56'h20, 1'b1, 3'd3, 64'd0, 8'hFF, 64'd0, 1'b0, 2);
        xfer("t2w", 0, B + 56'h20, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0, 1'b0, 2);
        xfer("t2r", 0, B + 56'h20, 1'b0, 3'd3, 64'd0, 8'h00, 64'h00000000FFFFFFFF, 1'b0, 2);

        // Zero wait states, read address phase overlapping the write data phase
        sb.push_back('{64'd0, 1'b0, 0});
        sb.push_back('{64'hAA, 1'b0, 0});
        @(negedge clk);
        sel = 3'b010; haddr = B + 56'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3;
        @(posedge clk); #1;
        hwrite = 1'b0; hwdata = 64'hAA; hwstrb = 8'hFF;
        @(negedge clk);
        e = sb.pop_front();
        check("t3w.rdy", 64'(rdy[1]), 64'd1);
        check("t3w.resp", 64'(resp[1]), 64'(e.resp));
        check("t3w.rdata", rdata[1], e.rdata);
        @(posedge clk); #1;
        sel = '0; htrans = 2'b00;
        @(negedge clk);
        e = sb.pop_front();
        check("t3r.rdy", 64'(rdy[1]), 64'd1);
        check("t3r.resp", 64'(resp[1]), 64'(e.resp));
        check("t3r.rdata", rdata[1], e.rdata);

        // Error responses; RAM must be untouched
        xfer("t4e", 0, B + 56'd65536, 1'b0, 3'd3, 64'd0, 8'h00, 64'd0, 1'b1, 1);
        xfer("t4r", 0, B + 56'h10, 1'b0, 3'd3, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 2);
        xfer("t5p", 0, B, 1'b1, 3'd3, 64'h1111, 8'hFF, 64'd0, 1'b0, 2);
        xfer("t5e", 0, B + 56'h4, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1, 1);
        xfer("t5s", 0, B, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1, 1);
        xfer("t5b", 0, B - 56'h8, 1'b0, 3'd3, 64'd0, 8'h00, 64'd0, 1'b1, 1);
        xfer("t5r", 0, B, 1'b0, 3'd3, 64'd0, 8'h00, 64'h1111, 1'b0, 2);

        // HTRANS=IDLE while selected is ignored
        @(negedge clk);
        sel = 3'b001; haddr = B + 56'h4; htrans = 2'b00; hsize = 3'd3;
        repeat (2) begin
            @(negedge clk);
            check("t5i.rdy", 64'(rdy[0]), 64'd1);
            check("t5i.resp", 64'(resp[0]), 64'd0);
        end
        sel = '0;

        // Three wait states, reset in the second wait cycle drops the write
        xfer("t6p", 2, B + 56'h30, 1'b1, 3'd3, 64'h5555, 8'hFF, 64'd0, 1'b0, 3);
        @(negedge clk);
        sel = 3'b100; haddr = B + 56'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3;
        @(posedge clk); #1;
        sel = '0; htrans = 2'b00; hwdata = 64'hDEAD; hwstrb = 8'hFF;
        @(negedge clk);
        check("t6.wait1", 64'(rdy[2]), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t6.wait2", 64'(rdy[2]), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t6.rdy", 64'(rdy[2]), 64'd1);
        check("t6.resp", 64'(resp[2]), 64'd0);
        check("t6.rdata", rdata[2], 64'd0);
        xfer("t6r", 2, B + 56'h30, 1'b0, 3'd3, 64'd0, 8'h00, 64'h5555, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
